addernet_pe: RTL and testbench



---
 rtl/addernet_pe.sv | 152 +++++++++++++++
 tb/tb_addernet_pe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/addernet_pe.sv
// AdderNet processing element: per-lane |if - w|, a registered adder tree and a
// window accumulator that reports -sum(|if - w|) with a beat count and a saturation flag.
module addernet_pe #(
    parameter int  NBIT   = 8,
    parameter int  NDATA  = 16,
    parameter int  BEAT_W = 4,
    localparam int LOG2N  = $clog2(NDATA),
    localparam int S      = NBIT + LOG2N,
    localparam int A      = S + BEAT_W
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_last,
    input  logic [NBIT*NDATA-1:0] i_if,
    input  logic [NBIT*NDATA-1:0] i_w,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [A:0]            o_result,
    output logic [BEAT_W:0]       o_nbeat,
    output logic                  o_sat
);

    // Bit offset of tree level l inside the flat tree register; level 0 holds the
    // per-lane magnitudes, and level l has NDATA>>l entries of NBIT+l bits.
    function automatic int lvl_off(input int l);
        int off;
        off = 0;
        for (int k = 0; k < l; k++) off += (NDATA >> k) * (NBIT + k);
        return off;
    endfunction

    localparam int TREE_BITS = lvl_off(LOG2N + 1);
    localparam int TOP       = LOG2N + 1;

    logic                  adv;
    logic [NBIT*NDATA-1:0] if_q, w_q;
    logic [TREE_BITS-1:0]  tree_q, tree_d;
    logic [TOP:0]          vld_q, last_q;

    logic [A-1:0]          acc_q, acc_d;
    logic [BEAT_W:0]       cnt_q, cnt_d, cnt_inc;
    logic                  sat_r_q, sat_r_d;
    logic [A:0]            result_q, result_d;
    logic [BEAT_W:0]       nbeat_q, nbeat_d;
    logic                  sat_q, sat_d;
    logic                  valid_q, valid_d;

    logic [S-1:0]          tree_sum;
    logic [A:0]            sum;
    logic                  ovf;
    logic [A-1:0]          clamped;

    assign adv      = ~valid_q | i_ready;
    assign o_ready  = adv;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_nbeat  = nbeat_q;
    assign o_sat    = sat_q;

    // Stage 1: |a - b| at NBIT+1 bits; the largest magnitude 2^NBIT-1 fits in NBIT bits.
    for (genvar k = 0; k < NDATA; k++) begin : g_abs
        logic [NBIT-1:0] a, b, mag;
        logic [NBIT:0]   diff;
        assign a    = if_q[NBIT*k +: NBIT];
        assign b    = w_q[NBIT*k +: NBIT];
        assign diff = {a[NBIT-1], a} - {b[NBIT-1], b};
        assign mag  = diff[NBIT] ? NBIT'(-diff) : diff[NBIT-1:0];
        assign tree_d[NBIT*k +: NBIT] = mag;
    end

    for (genvar l = 1; l <= LOG2N; l++) begin : g_lvl
        localparam int W       = NBIT + l;
        localparam int N       = NDATA >> l;
        localparam int IN_OFF  = lvl_off(l - 1);
        localparam int OUT_OFF = lvl_off(l);
        for (genvar j = 0; j < N; j++) begin : g_add
            assign tree_d[OUT_OFF + W*j +: W] =
                W'(tree_q[IN_OFF + (W-1)*(2*j)   +: W-1]) +
                W'(tree_q[IN_OFF + (W-1)*(2*j+1) +: W-1]);
        end
    end

    assign tree_sum = tree_q[TREE_BITS-1 -: S];
    assign sum      = {1'b0, acc_q} + (A+1)'(tree_sum);
    assign ovf      = sum[A];
    assign clamped  = ovf ? {A{1'b1}} : sum[A-1:0];
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so no path can leave a variable unassigned and infer a latch.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sat_r_d  = sat_r_q;
        result_d = result_q;
        nbeat_d  = nbeat_q;
        sat_d    = sat_q;
        valid_d  = 1'b0;
        if (vld_q[TOP]) begin
            if (last_q[TOP]) begin
                result_d = -{1'b0, clamped};
                nbeat_d  = cnt_inc;
                sat_d    = sat_r_q | ovf;
                valid_d  = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
                sat_r_d  = 1'b0;
            end else begin
                acc_d    = clamped;
                cnt_d    = cnt_inc;
                sat_r_d  = sat_r_q | ovf;
            end
        end
    end

    // NOTE: the datapath registers carry no reset; they are only ever observed
    // through a valid bit, and those valid bits are reset.
    always_ff @(posedge CLK) begin
        if (adv) begin
            if_q   <= i_if;
            w_q    <= i_w;
            tree_q <= tree_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_q    <= '0;
            last_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sat_r_q  <= 1'b0;
            result_q <= '0;
            nbeat_q  <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else if (adv) begin
            vld_q    <= {vld_q[TOP-1:0], i_valid};
            last_q   <= {last_q[TOP-1:0], i_last};
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sat_r_q  <= sat_r_d;
            result_q <= result_d;
            nbeat_q  <= nbeat_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_addernet_pe.sv
// Directed bench for addernet_pe at NBIT=8, NDATA=4, BEAT_W=2 (latency 5, A=12).
module tb_addernet_pe;

    localparam int NBIT   = 8;
    localparam int NDATA  = 4;
    localparam int BEAT_W = 2;
    localparam int A      = 12;

    localparam logic [31:0] V1_IF  = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] V1_W   = {8'd1, 8'd2, 8'd3, 8'd4};
    localparam logic [31:0] NEG    = {4{8'h80}};
    localparam logic [31:0] POS    = {4{8'h7F}};
    localparam logic [31:0] V3_IF  = {8'd7, 8'd0, 8'hFD, 8'd5};
    localparam logic [31:0] V3_W   = {8'hFF, 8'd0, 8'd4, 8'hFE};
    localparam logic [31:0] V4_IF  = 32'd0;
    localparam logic [31:0] V4_W   = {4{8'd1}};

    logic              CLK = 1'b0;
    logic              RSTN = 1'b0;
    logic              i_valid = 1'b0;
    logic              i_last = 1'b0;
    logic              i_ready = 1'b0;
    logic [31:0]       i_if = '0;
    logic [31:0]       i_w = '0;
    logic              o_ready, o_valid, o_sat;
    logic [A:0]        o_result;
    logic [BEAT_W:0]   o_nbeat;

    int n_checks = 0;
    int n_fail   = 0;

    addernet_pe #(.NBIT(NBIT), .NDATA(NDATA), .BEAT_W(BEAT_W)) dut (
        .CLK(CLK), .RSTN(RSTN), .i_valid(i_valid), .o_ready(o_ready), .i_last(i_last),
        .i_if(i_if), .i_w(i_w), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_nbeat(o_nbeat), .o_sat(o_sat)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic v, input logic last, input logic [31:0] f, input logic [31:0] w);
        @(negedge CLK);
        i_valid = v;
        i_last  = last;
        i_if    = f;
        i_w     = w;
    endtask

    task automatic wait_valid(input int max_cyc, output bit got);
        got = 1'b0;
        for (int c = 0; c < max_cyc && !got; c++) begin
            @(negedge CLK);
            if (o_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        n_checks++; if (o_result !== '0) begin n_fail++; $display("FAIL reset_o_result: got %0d want 0", $signed(o_result)); end
        n_checks++; if (o_nbeat !== '0) begin n_fail++; $display("FAIL reset_o_nbeat: got %0d want 0", o_nbeat); end
        n_checks++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL reset_o_sat: got %b want 0", o_sat); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
        @(negedge CLK);
        RSTN    = 1'b1;
        i_ready = 1'b1;
        #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL release_o_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_basic;
        drive(1'b1, 1'b1, V1_IF, V1_W);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            n_checks++;
            if (o_valid !== (k == 5)) begin
                n_fail++; $display("FAIL basic_latency cycle %0d: o_valid got %b want %b", k, o_valid, (k == 5));
            end
            if (k == 1) i_valid = 1'b0;
        end
        n_checks++; if (o_result !== 13'(-8)) begin n_fail++; $display("FAIL basic_result: got %0d want -8", $signed(o_result)); end
        n_checks++; if (o_nbeat !== 3'd1) begin n_fail++; $display("FAIL basic_nbeat: got %0d want 1", o_nbeat); end
        n_checks++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b want 0", o_sat); end
        @(negedge CLK);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: o_valid got %b want 0", o_valid); end
    endtask

    task automatic test_extremes;
        bit got;
        drive(1'b1, 1'b1, NEG, POS);
        drive(1'b1, 1'b1, POS, NEG);
        drive(1'b0, 1'b0, '0, '0);
        wait_valid(10, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL ext_timeout: no o_valid within 10 cycles"); end
        n_checks++; if (o_result !== 13'(-1020)) begin n_fail++; $display("FAIL ext_result_a: got %0d want -1020", $signed(o_result)); end
        @(negedge CLK);
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ext_second_valid: got %b want 1", o_valid); end
        n_checks++; if (o_result !== 13'(-1020)) begin n_fail++; $display("FAIL ext_result_b: got %0d want -1020", $signed(o_result)); end
        n_checks++; if (o_nbeat !== 3'd1) begin n_fail++; $display("FAIL ext_nbeat: got %0d want 1", o_nbeat); end
    endtask

    task automatic test_multi_beat;
        int n_valid;
        logic [A:0] res;
        logic [BEAT_W:0] nb;
        n_valid = 0; res = '0; nb = '0;
        drive(1'b1, 1'b0, V1_IF, V1_W);
        drive(1'b1, 1'b0, V1_IF, V1_W);
        drive(1'b1, 1'b1, V1_IF, V1_W);
        drive(1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (o_valid === 1'b1) begin n_valid++; res = o_result; nb = o_nbeat; end
        end
        n_checks++; if (n_valid != 1) begin n_fail++; $display("FAIL multi_pulses: got %0d want 1", n_valid); end
        n_checks++; if (res !== 13'(-24)) begin n_fail++; $display("FAIL multi_result: got %0d want -24", $signed(res)); end
        n_checks++; if (nb !== 3'd3) begin n_fail++; $display("FAIL multi_nbeat: got %0d want 3", nb); end
    endtask

    task automatic test_saturation;
        bit got;
        for (int b = 0; b < 5; b++) drive(1'b1, (b == 4), NEG, POS);
        drive(1'b0, 1'b0, '0, '0);
        wait_valid(12, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL sat_timeout: no o_valid within 12 cycles"); end
        n_checks++; if (o_result !== 13'(-4095)) begin n_fail++; $display("FAIL sat_result: got %0d want -4095", $signed(o_result)); end
        n_checks++; if (o_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b want 1", o_sat); end
        n_checks++; if (o_nbeat !== 3'd5) begin n_fail++; $display("FAIL sat_nbeat: got %0d want 5", o_nbeat); end

        drive(1'b1, 1'b1, V1_IF, V1_W);
        drive(1'b0, 1'b0, '0, '0);
        wait_valid(10, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL sat_next_timeout: no o_valid within 10 cycles"); end
        n_checks++; if (o_result !== 13'(-8)) begin n_fail++; $display("FAIL sat_next_result: got %0d want -8", $signed(o_result)); end
        n_checks++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL sat_next_flag: got %b want 0", o_sat); end

        for (int b = 0; b < 9; b++) drive(1'b1, (b == 8), V1_IF, V1_W);
        drive(1'b0, 1'b0, '0, '0);
        wait_valid(12, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL nbeat_sat_timeout: no o_valid within 12 cycles"); end
        n_checks++; if (o_result !== 13'(-72)) begin n_fail++; $display("FAIL nbeat_sat_result: got %0d want -72", $signed(o_result)); end
        n_checks++; if (o_nbeat !== 3'd7) begin n_fail++; $display("FAIL nbeat_sat_count: got %0d want 7", o_nbeat); end
        n_checks++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL nbeat_sat_flag: got %b want 0", o_sat); end
    endtask

    task automatic test_back_to_back;
        bit got;
        logic [A:0] got_q[$];
        logic [A:0] exp_r [4];
        exp_r[0] = 13'(-8); exp_r[1] = 13'(-1020); exp_r[2] = 13'(-22); exp_r[3] = 13'(-4);
        @(negedge CLK);
        i_ready = 1'b0;
        drive(1'b1, 1'b1, V1_IF, V1_W);
        drive(1'b1, 1'b1, NEG, POS);
        drive(1'b1, 1'b1, V3_IF, V3_W);
        drive(1'b0, 1'b0, '0, '0);
        wait_valid(12, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL bp_timeout: no o_valid within 12 cycles"); end
        i_valid = 1'b1; i_last = 1'b1; i_if = V4_IF; i_w = V4_W;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) @(negedge CLK);
            n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %b want 0", s, o_ready); end
            n_checks++; if (o_result !== 13'(-8)) begin n_fail++; $display("FAIL bp_hold cycle %0d: got %0d want -8", s, $signed(o_result)); end
        end
        @(negedge CLK);
        i_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge CLK);
            if (c == 1) i_valid = 1'b0;
            if (o_valid === 1'b1) got_q.push_back(o_result);
        end
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d results want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_r[i]) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, $signed(got_q[i]), $signed(exp_r[i]));
            end
        end
    endtask

    task automatic test_reset_midwindow;
        bit got;
        int n_valid;
        logic [A:0] res;
        logic [BEAT_W:0] nb;
        logic s;
        n_valid = 0; res = '0; nb = '0; s = 1'b1;
        drive(1'b1, 1'b1, NEG, POS);
        drive(1'b1, 1'b0, V1_IF, V1_W);
        drive(1'b1, 1'b0, V1_IF, V1_W);
        drive(1'b0, 1'b0, '0, '0);
        wait_valid(10, got);
        n_checks++; if (!got || o_result !== 13'(-1020)) begin n_fail++; $display("FAIL rst_pre_result: got %0d want -1020", $signed(o_result)); end
        i_ready = 1'b0;
        #2 RSTN = 1'b0;
        #1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_o_valid: got %b want 0", o_valid); end
        n_checks++; if (o_result !== '0) begin n_fail++; $display("FAIL rst_mid_o_result: got %0d want 0", $signed(o_result)); end
        n_checks++; if (o_nbeat !== '0) begin n_fail++; $display("FAIL rst_mid_o_nbeat: got %0d want 0", o_nbeat); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_o_ready: got %b want 1", o_ready); end
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        i_ready = 1'b1;
        drive(1'b1, 1'b1, V1_IF, V1_W);
        drive(1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (o_valid === 1'b1) begin
                n_valid++;
                if (n_valid == 1) begin res = o_result; nb = o_nbeat; s = o_sat; end
            end
        end
        n_checks++; if (n_valid != 1) begin n_fail++; $display("FAIL rst_post_pulses: got %0d want 1", n_valid); end
        n_checks++; if (res !== 13'(-8)) begin n_fail++; $display("FAIL rst_post_result: got %0d want -8", $signed(res)); end
        n_checks++; if (nb !== 3'd1) begin n_fail++; $display("FAIL rst_post_nbeat: got %0d want 1", nb); end
        n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL rst_post_sat: got %b want 0", s); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_multi_beat();
        test_saturation();
        test_back_to_back();
        test_reset_midwindow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
